onchip_memory_pipelined: RTL and testbench
==========================================

Name: onchip_memory_pipelined

Overview:
Parametrised successor to the fixed 16-bit x 32K single-port on-chip RAM slave. It is an Avalon-MM pipelined slave with configurable width, depth and read latency. It adds readdatavalid/waitrequest handshaking and a hardware clear engine that zero-fills the array on request or after reset. It sits on the system interconnect as the general program/data memory for the soft-processor platform.

Parameters:
DATA_WIDTH, 16, data bus width in bits; multiple of 8, range 8..128
ADDR_WIDTH, 15, word-address width
DEPTH, 2**ADDR_WIDTH, implemented words; must be <= 2**ADDR_WIDTH
READ_LATENCY, 1, cycles from read acceptance to readdatavalid; 1 or 2 (2 adds output register)
CLEAR_ON_RESET, 0, 1 = run clear sweep automatically after reset_n deasserts
INIT_FILE, "", hex image loaded at elaboration; empty = array starts undefined

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  ADDR_WIDTH  word address
byteenable  in  DATA_WIDTH/8  write byte lanes
chipselect  in  1  slave select
read  in  1  read request
write  in  1  write request
writedata  in  DATA_WIDTH  write data
readdata  out  DATA_WIDTH  read data, qualified by readdatavalid
readdatavalid  out  1  one-cycle pulse per accepted read
waitrequest  out  1  slave not accepting commands this cycle
clken  in  1  clock enable; 0 freezes array and read pipeline
reset_req  in  1  reset-request guard; 1 blocks all array access
clear_req  in  1  one-cycle pulse that starts a zero-fill sweep
clear_busy  out  1  high while the clear FSM is not IDLE

Behaviour:
- Reset (reset_n=0, async): readdata=0, readdatavalid=0, clear_busy=0, pipeline valids cleared, FSM=IDLE. waitrequest=1 while reset is asserted. Array contents are not reset.
- After reset release: FSM goes to CLEAR if CLEAR_ON_RESET=1, otherwise stays in IDLE.
- waitrequest = (FSM!=IDLE) | ~clken | reset_req. Combinational from state and inputs, with no dependence on address or data.
- Accept = chipselect & (read|write) & ~waitrequest.
- If read and write are both high, the write is performed and the read is dropped (no readdatavalid).
- Write: lanes with byteenable[i]=1 are updated at the accepting edge. byteenable all-zero leaves the array unchanged but still consumes the cycle.
- Read: readdatavalid pulses exactly READ_LATENCY enabled cycles after acceptance. Throughput is 1 read/cycle, with back-to-back pipelining.
- readdata holds its last value between pulses.
- A read accepted the cycle after a write to the same address returns the new data.
- address >= DEPTH: write is dropped; read returns 0 with normal latency.
- clken=0: array and pipeline registers hold and readdatavalid is forced 0. The pending pulse is delivered once clken returns; no loss or duplication.
- reset_req=1: same freeze as clken=0, and the array is not written.
- FSM states:
  - IDLE: on clear_req go to DRAIN.
  - DRAIN: waitrequest=1; wait for the read pipeline to empty, then go to CLEAR with the counter at 0.
  - CLEAR: write all-zero data to the counter address. The counter advances only when clken=1 and reset_req=0. After writing DEPTH-1, go to IDLE; total DEPTH enabled cycles.
- clear_req is ignored outside IDLE.
- clear_busy=1 in DRAIN and CLEAR.
- reset_n asserted mid-clear aborts the sweep, leaving partial contents. The sweep restarts from 0 only if CLEAR_ON_RESET=1.
- Counter width is ADDR_WIDTH+1 bits so DEPTH=2**ADDR_WIDTH terminates without wrap.

Decomposition:
- Package onchip_mem_pkg holds:
  - FSM state enum {IDLE, DRAIN, CLEAR}
  - legal READ_LATENCY constants (1, 2)
  - a function giving byte-lane count from DATA_WIDTH
- Sub-module onchip_mem_array: inferred byte-enabled single-port RAM with registered read, clock enable and INIT_FILE load.
- The top level owns the handshake logic, latency pipeline and clear FSM.

Test Plan:
- Writes: write 0xBEEF to addr 5 (be=2'b11), then 0x12xx to addr 5 with be=2'b10 data 0x1234, then read addr 5 -> readdata=0x12EF with readdatavalid exactly 1 cycle after acceptance (LAT=1).
- Back-to-back reads: LAT=2, reads to addr 0,1,2,3 on consecutive cycles -> four consecutive readdatavalid pulses starting 2 cycles after the first accept, data in order.
- clken stall: clken=0 for 3 cycles right after a read is accepted -> waitrequest=1, no readdatavalid during the stall; exactly one pulse 1 cycle after clken returns, correct data.
- Clear sweep: DEPTH=16, preload nonzero, pulse clear_req with a read in flight -> read completes first; clear_busy high for drain + 16 cycles; all subsequent reads return 0.
- Reset mid-clear: assert reset_n=0 at word 7 of the sweep with CLEAR_ON_RESET=0 -> clear_busy=0, words 0..6 read 0, words 7..15 keep prior values.
- Edge cases: read and write asserted in the same cycle -> write applied, no readdatavalid. Address DEPTH+1 on a DEPTH < 2**ADDR_WIDTH build -> write ignored, read returns 0.

Source files
------------

// File: rtl/onchip_memory_pipelined_pkg.sv
// Shared types and helpers for the pipelined on-chip memory slave.
// Holds the clear-engine state encoding, legal read latencies and sizing helpers.
// Imported by the interface, the RAM array and the top level.
package onchip_mem_pkg;

    // Clear engine states: normal service, wait for reads to retire, zero-fill sweep
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } clr_state_t;

    // Read latency 1 = RAM read register only, 2 = extra output register
    localparam int LAT_REG  = 1;
    localparam int LAT_OREG = 2;

    // Number of byte lanes on a data bus of the given width
    function automatic int lane_count(input int data_width);
        return data_width / 8;
    endfunction

    // Index bits needed to address every implemented word
    function automatic int addr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/onchip_memory_pipelined_if.sv
// Avalon-MM pipelined slave bus bundle between interconnect and memory.
// No logic: plain wires grouped for the command, write data and read return paths.
// waitrequest flows back to the master; the slave never needs the master's readiness.
interface onchip_memory_pipelined_if
    import onchip_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 15
);
    logic [ADDR_WIDTH-1:0]               address;
    logic [lane_count(DATA_WIDTH)-1:0]   byteenable;
    logic                                chipselect;
    logic                                read;
    logic                                write;
    logic [DATA_WIDTH-1:0]               writedata;
    logic [DATA_WIDTH-1:0]               readdata;
    logic                                readdatavalid;
    logic                                waitrequest;

    modport master (
        output address, byteenable, chipselect, read, write, writedata,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, byteenable, chipselect, read, write, writedata,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/onchip_memory_pipelined_array.sv
// Inferred single-port RAM with byte-lane writes and a registered read port.
// Latency: read data appears one enabled clock after the read strobe.
// Backpressure: none; en=0 freezes both the array and the read register.
module onchip_mem_array
    import onchip_mem_pkg::*;
#(
    parameter int    DATA_WIDTH = 16,
    parameter int    DEPTH      = 32768,
    parameter string INIT_FILE  = ""
) (
    input  logic                                clk,
    input  logic                                en,
    input  logic [addr_bits(DEPTH)-1:0]         addr,
    input  logic                                we,
    input  logic [lane_count(DATA_WIDTH)-1:0]   be,
    input  logic [DATA_WIDTH-1:0]               wdata,
    input  logic                                re,
    output logic [DATA_WIDTH-1:0]               rdata
);
    localparam int LANES = lane_count(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Byte-lane write and registered read; the read register only moves on a read
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < LANES; i++) begin
                    if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
            if (re) rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/onchip_memory_pipelined.sv
// Avalon-MM pipelined memory slave with zero-fill clear engine.
// Latency: readdatavalid READ_LATENCY enabled cycles after read acceptance, 1 read/cycle.
// Backpressure: waitrequest while clearing/draining, clken low, reset_req high or in reset.
module onchip_memory_pipelined
    import onchip_mem_pkg::*;
#(
    parameter int    DATA_WIDTH     = 16,
    parameter int    ADDR_WIDTH     = 15,
    parameter int    DEPTH          = 2**ADDR_WIDTH,
    parameter int    READ_LATENCY   = LAT_REG,
    parameter int    CLEAR_ON_RESET = 0,
    parameter string INIT_FILE      = ""
) (
    input  logic                       clk,
    input  logic                       reset_n,
    onchip_memory_pipelined_if.slave   bus,
    input  logic                       clken,
    input  logic                       reset_req,
    input  logic                       clear_req,
    output logic                       clear_busy
);
    localparam int LANES = lane_count(DATA_WIDTH);
    localparam int IW    = addr_bits(DEPTH);
    // One extra bit so a full-range sweep ends without the counter wrapping
    localparam int CW    = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] LAST_C  = CW'(DEPTH - 1);

    clr_state_t               state;
    logic [CW-1:0]            cnt;
    logic                     boot_pend;

    logic                     en;
    logic                     stall;
    logic                     acc;
    logic                     wr_acc;
    logic                     rd_acc;
    logic                     in_range;
    logic                     clearing;
    logic                     pipe_empty;

    logic                     ram_we;
    logic                     ram_re;
    logic [IW-1:0]            ram_addr;
    logic [LANES-1:0]         ram_be;
    logic [DATA_WIDTH-1:0]    ram_wdata;
    logic [DATA_WIDTH-1:0]    ram_q;

    logic                     s1_vld;
    logic                     s1_oor;
    logic [DATA_WIDTH-1:0]    s1_dat;
    logic                     out_vld;
    logic [DATA_WIDTH-1:0]    out_dat;
    logic                     rdv;
    logic [DATA_WIDTH-1:0]    hold_dat;

    // clken and reset_req freeze everything that holds read or array state
    assign en = clken & ~reset_req;

    // Depends only on state and control inputs, never on address or data
    assign stall = ~reset_n | (state != IDLE) | boot_pend | ~clken | reset_req;
    assign bus.waitrequest = stall;

    assign in_range = {1'b0, bus.address} < DEPTH_C;
    assign acc      = bus.chipselect & (bus.read | bus.write) & ~stall;
    assign wr_acc   = acc & bus.write;
    // A simultaneous read+write is treated as a write only
    assign rd_acc   = acc & bus.read & ~bus.write;
    assign clearing = (state == CLEAR);

    // The sweep owns the single RAM port while clearing; the bus is stalled then
    assign ram_we    = clearing | (wr_acc & in_range);
    assign ram_re    = rd_acc & in_range;
    assign ram_addr  = clearing ? cnt[IW-1:0] : bus.address[IW-1:0];
    assign ram_be    = clearing ? {LANES{1'b1}} : bus.byteenable;
    assign ram_wdata = clearing ? '0 : bus.writedata;

    onchip_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .INIT_FILE  (INIT_FILE)
    ) u_array (
        .clk   (clk),
        .en    (en),
        .addr  (ram_addr),
        .we    (ram_we),
        .be    (ram_be),
        .wdata (ram_wdata),
        .re    (ram_re),
        .rdata (ram_q)
    );

    // Stage 1 tracks the RAM read register: valid plus out-of-range marker
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_vld <= 1'b0;
            s1_oor <= 1'b0;
        end else if (en) begin
            s1_vld <= rd_acc;
            s1_oor <= ~in_range;
        end
    end

    // Out-of-range reads return zero instead of stale RAM output
    assign s1_dat = s1_oor ? '0 : ram_q;

    if (READ_LATENCY == LAT_OREG) begin : g_oreg
        logic                  s2_vld;
        logic [DATA_WIDTH-1:0] s2_dat;

        // Extra output register stage for the two-cycle build
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                s2_vld <= 1'b0;
                s2_dat <= '0;
            end else if (en) begin
                s2_vld <= s1_vld;
                s2_dat <= s1_dat;
            end
        end

        assign out_vld    = s2_vld;
        assign out_dat    = s2_dat;
        assign pipe_empty = ~s1_vld & ~s2_vld;
    end else begin : g_noreg
        assign out_vld    = s1_vld;
        assign out_dat    = s1_dat;
        assign pipe_empty = ~s1_vld;
    end

    // A pending result waits in its stage while frozen, so it is delivered once
    assign rdv = out_vld & en;
    assign bus.readdatavalid = rdv;
    assign bus.readdata      = rdv ? out_dat : hold_dat;

    // Remember the last delivered word so readdata is stable between pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_dat <= '0;
        end else if (rdv) begin
            hold_dat <= out_dat;
        end
    end

    // Clear engine: drain in-flight reads, then write zero to every word
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            clear_busy <= 1'b0;
            boot_pend  <= (CLEAR_ON_RESET != 0);
        end else begin
            case (state)
                IDLE: begin
                    if (boot_pend || clear_req) begin
                        boot_pend  <= 1'b0;
                        clear_busy <= 1'b1;
                        cnt        <= '0;
                        // Nothing can be in flight straight out of reset
                        state      <= boot_pend ? CLEAR : DRAIN;
                    end
                end
                DRAIN: begin
                    if (pipe_empty) begin
                        state <= CLEAR;
                        cnt   <= '0;
                    end
                end
                CLEAR: begin
                    if (en) begin
                        if (cnt == LAST_C) begin
                            state      <= IDLE;
                            clear_busy <= 1'b0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    clear_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_onchip_memory_pipelined.sv
// Bench for the pipelined memory slave: one latency-1 and one latency-2 instance
// share all stimulus; a queue-based reference model tracks array contents and
// the enabled-cycle due time of every read result.
module tb_onchip_memory_pipelined;
    localparam int DW    = 16;
    localparam int AW    = 5;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [AW-1:0] address;
    logic [1:0]    byteenable;
    logic          chipselect;
    logic          read;
    logic          write;
    logic [DW-1:0] writedata;
    logic          clken;
    logic          reset_req;
    logic          clear_req;
    logic          busy1;
    logic          busy2;

    onchip_memory_pipelined_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();
    onchip_memory_pipelined_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus2 ();

    assign bus1.address    = address;
    assign bus1.byteenable = byteenable;
    assign bus1.chipselect = chipselect;
    assign bus1.read       = read;
    assign bus1.write      = write;
    assign bus1.writedata  = writedata;
    assign bus2.address    = address;
    assign bus2.byteenable = byteenable;
    assign bus2.chipselect = chipselect;
    assign bus2.read       = read;
    assign bus2.write      = write;
    assign bus2.writedata  = writedata;

    onchip_memory_pipelined #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
        .READ_LATENCY(1), .CLEAR_ON_RESET(0), .INIT_FILE("")
    ) d1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1.slave), .clken(clken),
        .reset_req(reset_req), .clear_req(clear_req), .clear_busy(busy1)
    );

    onchip_memory_pipelined #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
        .READ_LATENCY(2), .CLEAR_ON_RESET(0), .INIT_FILE("")
    ) d2 (
        .clk(clk), .reset_n(reset_n), .bus(bus2.slave), .clken(clken),
        .reset_req(reset_req), .clear_req(clear_req), .clear_busy(busy2)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    typedef struct {
        int            due;
        logic [DW-1:0] dat;
    } item_t;

    logic [DW-1:0] mem_m [DEPTH];
    item_t         pq1 [$];
    item_t         pq2 [$];
    logic [DW-1:0] last1;
    logic [DW-1:0] last2;
    int            ecnt;
    bit            mon_on = 1'b0;

    logic          m_en;
    logic          m_acc;
    logic          m_v;
    logic [DW-1:0] m_d;

    // Per-cycle check of both instances, then advance the model over the next edge
    always @(negedge clk) begin
        if (mon_on) begin
            m_en = clken && !reset_req;
            chk("wait1", bus1.waitrequest, !m_en);
            chk("wait2", bus2.waitrequest, !m_en);
            chk("busy1", busy1, 1'b0);
            chk("busy2", busy2, 1'b0);

            m_v = 1'b0;
            if (m_en && pq1.size() > 0) m_v = (pq1[0].due == ecnt);
            m_d = m_v ? pq1[0].dat : last1;
            chk("rdv1", bus1.readdatavalid, m_v);
            chk("rdata1", bus1.readdata, m_d);
            if (m_v) begin
                last1 = m_d;
                void'(pq1.pop_front());
            end

            m_v = 1'b0;
            if (m_en && pq2.size() > 0) m_v = (pq2[0].due == ecnt);
            m_d = m_v ? pq2[0].dat : last2;
            chk("rdv2", bus2.readdatavalid, m_v);
            chk("rdata2", bus2.readdata, m_d);
            if (m_v) begin
                last2 = m_d;
                void'(pq2.pop_front());
            end

            m_acc = chipselect && (read || write) && m_en;
            if (m_acc && write) begin
                if (address < AW'(DEPTH)) begin
                    for (int i = 0; i < 2; i++) begin
                        if (byteenable[i]) mem_m[address[3:0]][i*8 +: 8] = writedata[i*8 +: 8];
                    end
                end
            end else if (m_acc && read) begin
                m_d = (address < AW'(DEPTH)) ? mem_m[address[3:0]] : '0;
                pq1.push_back('{due: ecnt + 1, dat: m_d});
                pq2.push_back('{due: ecnt + 2, dat: m_d});
            end
            if (m_en) ecnt++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        repeat (n) cyc();
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] be);
        address = a; writedata = d; byteenable = be;
        chipselect = 1'b1; write = 1'b1; read = 1'b0;
        cyc();
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a);
        address = a; chipselect = 1'b1; read = 1'b1; write = 1'b0;
        cyc();
        chipselect = 1'b0; read = 1'b0;
    endtask

    task automatic preload();
        for (int i = 0; i < DEPTH; i++) wr(AW'(i), DW'($urandom_range(1, 65535)), 2'b11);
    endtask

    task automatic read_all();
        for (int i = 0; i < DEPTH; i++) rd(AW'(i));
        idle(4);
    endtask

    int            p1, p2, b1, b2, t1, t2;
    logic [DW-1:0] g1, g2, exp_d;

    initial begin
        address = '0; byteenable = '0; chipselect = 1'b0; read = 1'b0; write = 1'b0;
        writedata = '0; clken = 1'b1; reset_req = 1'b0; clear_req = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_wait1", bus1.waitrequest, 1'b1);
        chk("rst_wait2", bus2.waitrequest, 1'b1);
        chk("rst_rdv1", bus1.readdatavalid, 1'b0);
        chk("rst_rdv2", bus2.readdatavalid, 1'b0);
        chk("rst_rdata1", bus1.readdata, 16'h0);
        chk("rst_rdata2", bus2.readdata, 16'h0);
        chk("rst_busy1", busy1, 1'b0);
        chk("rst_busy2", busy2, 1'b0);
        cyc();
        reset_n = 1'b1;
        last1 = '0; last2 = '0; ecnt = 0;
        mon_on = 1'b1;

        preload();
        // Byte-lane merge: 0xBEEF then upper lane 0x12 gives 0x12EF
        wr(5'd5, 16'hBEEF, 2'b11);
        wr(5'd5, 16'h1234, 2'b10);
        rd(5'd5);
        idle(3);
        wr(5'd6, 16'h5555, 2'b00);
        rd(5'd6);
        idle(3);

        // Back-to-back reads
        for (int i = 0; i < 4; i++) rd(AW'(i));
        idle(4);

        // Write then immediate read of the same word
        wr(5'd8, 16'hA5C3, 2'b11);
        rd(5'd8);
        idle(3);

        // clken stall right after a read is accepted
        rd(5'd7);
        clken = 1'b0;
        repeat (3) cyc();
        clken = 1'b1;
        idle(3);

        // Read and write together: write wins, no read return
        address = 5'd9; writedata = 16'h0F0F; byteenable = 2'b11;
        chipselect = 1'b1; read = 1'b1; write = 1'b1;
        cyc();
        idle(1);
        rd(5'd9);
        idle(3);

        // Out-of-range write must not alias onto word 1; read returns 0
        wr(5'd17, 16'hAAAA, 2'b11);
        rd(5'd17);
        rd(5'd1);
        idle(3);

        // reset_req blocks the array while a write is presented
        reset_req = 1'b1;
        wr(5'd2, 16'hDEAD, 2'b11);
        cyc();
        reset_req = 1'b0;
        rd(5'd2);
        idle(3);

        // Randomised traffic with stalls
        for (int n = 0; n < 600; n++) begin
            chipselect = ($urandom_range(0, 9) != 0);
            read       = 1'($urandom_range(0, 1));
            write      = ($urandom_range(0, 3) == 0);
            address    = AW'($urandom_range(0, 20));
            byteenable = 2'($urandom);
            writedata  = DW'($urandom);
            clken      = ($urandom_range(0, 9) != 0);
            reset_req  = ($urandom_range(0, 19) == 0);
            cyc();
        end
        clken = 1'b1;
        reset_req = 1'b0;
        idle(5);

        // Clear sweep with a read accepted in the same cycle as clear_req
        mon_on = 1'b0;
        exp_d = mem_m[3];
        address = 5'd3; chipselect = 1'b1; read = 1'b1; write = 1'b0; clear_req = 1'b1;
        cyc();
        chipselect = 1'b0; read = 1'b0; clear_req = 1'b0;
        p1 = 0; p2 = 0; b1 = 0; b2 = 0; t1 = 0; t2 = 0; g1 = '0; g2 = '0;
        for (int t = 1; t < 80; t++) begin
            @(negedge clk);
            if (bus1.readdatavalid) begin p1++; g1 = bus1.readdata; t1 = t; end
            if (bus2.readdatavalid) begin p2++; g2 = bus2.readdata; t2 = t; end
            if (busy1) b1++;
            if (busy2) b2++;
            if (t == 5) chk("clr_wait", bus1.waitrequest, 1'b1);
            if (t > 3 && !busy1 && !busy2) break;
        end
        chk("clr_done", {busy1, busy2}, 2'b00);
        chk("clr_pulses1", p1, 1);
        chk("clr_pulses2", p2, 1);
        chk("clr_when1", t1, 1);
        chk("clr_when2", t2, 2);
        chk("clr_data1", g1, exp_d);
        chk("clr_data2", g2, exp_d);
        chk("clr_len1_lo", b1 >= DEPTH + 1, 1'b1);
        chk("clr_len1_hi", b1 <= DEPTH + 2, 1'b1);
        chk("clr_len2_lo", b2 >= DEPTH + 1, 1'b1);
        chk("clr_len2_hi", b2 <= DEPTH + 3, 1'b1);
        cyc();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        last1 = exp_d; last2 = exp_d;
        mon_on = 1'b1;
        read_all();

        // Reset in the middle of a sweep, just before word 7 is written
        preload();
        idle(2);
        mon_on = 1'b0;
        clear_req = 1'b1;
        cyc();
        clear_req = 1'b0;
        repeat (8) cyc();
        reset_n = 1'b0;
        @(negedge clk);
        chk("mid_busy1", busy1, 1'b0);
        chk("mid_busy2", busy2, 1'b0);
        chk("mid_wait1", bus1.waitrequest, 1'b1);
        chk("mid_rdata2", bus2.readdata, 16'h0);
        cyc();
        reset_n = 1'b1;
        for (int i = 0; i < 7; i++) mem_m[i] = '0;
        last1 = '0; last2 = '0;
        mon_on = 1'b1;
        idle(3);
        read_all();

        mon_on = 1'b0;
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog bench did not reach its end, total=%0d bad=%0d", n_chk, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
